// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry block and the ALU that consumes it.
package operand_entry_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    ISSUE   = 2'd3
  } entry_state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

endpackage

// File: rtl/entry_idle_timer.sv
// Idle counter that flags expiry once it has run TICKS-1 ticks without a clear.
module entry_idle_timer #(
  parameter int TICKS = 500
) (
  input  logic clock_10ms,
  input  logic resetN,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CW-1:0] count;

  assign expire = run && (count == CW'(TICKS - 1));

  always_ff @(posedge clock_10ms or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Collects operand A, operand B and opcode from the front panel, then issues them with a ready/ack handshake.
// Optional partial-entry abandonment is enabled by defining ENTRY_TIMEOUT_EN.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int TIMEOUT_TICKS = 500
) (
  input  logic             clock_10ms,
  input  logic             resetN,
  input  logic             enterValid,
  input  logic             clearValid,
  input  logic [WIDTH-1:0] switches,
  input  logic [1:0]       opSwitches,
  input  logic             aluAck,
  output logic [WIDTH-1:0] operandA,
  output logic [WIDTH-1:0] operandB,
  output logic [1:0]       opcode,
  output logic             entryReady,
  output logic [1:0]       stage,
  output logic             timeoutFlag
);

  entry_state_t state;
  logic         timeout;

`ifdef ENTRY_TIMEOUT_EN
  logic run;
  logic expire;

  assign run = (state == LOAD_B) || (state == LOAD_OP);

  entry_idle_timer #(
    .TICKS(TIMEOUT_TICKS)
  ) u_idle_timer (
    .clock_10ms(clock_10ms),
    .resetN    (resetN),
    .clear     (enterValid || clearValid),
    .run       (run),
    .expire    (expire)
  );

  // An enter or clear on the expiry cycle takes priority over abandoning the entry.
  assign timeout = expire && !enterValid && !clearValid;
`else
  assign timeout = 1'b0;
`endif

  assign timeoutFlag = timeout;
  assign stage       = state;

  always_ff @(posedge clock_10ms or negedge resetN) begin
    if (!resetN) begin
      state      <= LOAD_A;
      operandA   <= '0;
      operandB   <= '0;
      opcode     <= OP_ADD;
      entryReady <= 1'b0;
    end else if (clearValid || timeout) begin
      state      <= LOAD_A;
      operandA   <= '0;
      operandB   <= '0;
      opcode     <= OP_ADD;
      entryReady <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (enterValid) begin
          operandA <= switches;
          state    <= LOAD_B;
        end
        LOAD_B: if (enterValid) begin
          operandB <= switches;
          state    <= LOAD_OP;
        end
        LOAD_OP: if (enterValid) begin
          opcode     <= opSwitches;
          entryReady <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: if (aluAck) begin
          entryReady <= 1'b0;
          state      <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Collects one calculator operation from the debounced front panel and hands it to the ALU. Each debounced enter pulse latches the next field from the switches: operand A, then operand B, then the opcode. The block then presents all three with a ready/ack handshake. It sits directly downstream of the button debounce stages and directly upstream of the ALU and display logic.

## Interface
Parameters:
- WIDTH, 8: operand width in bits.
- TIMEOUT_TICKS, 500: idle ticks before a partial entry is abandoned (5 s at 10 ms). Used only with ENTRY_TIMEOUT_EN.

Ports:
- clock_10ms  in  1  system tick clock; all state changes on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- enterValid  in  1  one-cycle pulse from the enter-button debounce.
- clearValid  in  1  one-cycle pulse from the clear-button debounce.
- switches  in  WIDTH  operand value from the panel switches.
- opSwitches  in  2  opcode select: 0 add, 1 subtract, 2 multiply, 3 divide.
- aluAck  in  1  ALU has taken the current operation.
- operandA  out  WIDTH  latched first operand.
- operandB  out  WIDTH  latched second operand.
- opcode  out  2  latched opcode.
- entryReady  out  1  operation valid, held until acknowledged.
- stage  out  2  current state encoding, for the display.
- timeoutFlag  out  1  one-cycle pulse when a partial entry is abandoned.

## Operation
- States and encodings: LOAD_A (0), LOAD_B (1), LOAD_OP (2), ISSUE (3).
- Reset values: state LOAD_A, all outputs 0.
- LOAD_A + enterValid: operandA ← switches, go to LOAD_B.
- LOAD_B + enterValid: operandB ← switches, go to LOAD_OP.
- LOAD_OP + enterValid: opcode ← opSwitches, go to ISSUE, entryReady ← 1.
- ISSUE:
  - enterValid is ignored.
  - aluAck returns the block to LOAD_A and clears entryReady.
  - Operands and opcode keep their values until they are overwritten.
- aluAck outside ISSUE is ignored.
- clearValid in any state:
  - go to LOAD_A;
  - operandA, operandB, opcode and entryReady ← 0.
- Simultaneous events:
  - clearValid + enterValid in the same cycle: clear wins and the enter is dropped.
  - clearValid + aluAck in ISSUE: clear wins. The ALU still counts the handshake as complete, because entryReady was high in that cycle.
- Pulses on consecutive cycles are legal; each one advances one state.
- stage always equals the state encoding.

## Timing
- All inputs are sampled on the rising edge of clock_10ms.
- Latched values and the new state are visible the cycle after the sampling edge.
- entryReady rises exactly 1 cycle after the opcode enter pulse.
- entryReady falls 1 cycle after the edge that samples aluAck high.
- Handshake rules:
  - The ALU must not assert aluAck unless it sees entryReady high.
  - operandA, operandB and opcode are stable for the whole time entryReady is high.
- resetN low at any time (including mid-entry or in ISSUE) immediately forces reset values, with no clock edge needed.
- Releasing resetN is synchronised externally; the block needs no internal release logic.

## Configuration
ENTRY_TIMEOUT_EN

Defined:
- An idle counter runs only in LOAD_B and LOAD_OP.
- The counter clears on:
  - enterValid;
  - clearValid;
  - entering LOAD_B from LOAD_A.
- On the cycle the counter reaches TIMEOUT_TICKS-1:
  - go to LOAD_A;
  - operands and opcode ← 0;
  - timeoutFlag pulses for 1 cycle.
- enterValid in that same cycle wins; the timeout is suppressed.
- Counter width is $clog2(TIMEOUT_TICKS).

Undefined:
- No counter exists.
- timeoutFlag is tied to 0.
- A partial entry waits indefinitely.

## Structure
- Shared package holds:
  - the state enum and its encodings;
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV, which the ALU also uses.
- One sub-module, entry_idle_timer: a counter with clear, run and expire ports. It is instantiated only under ENTRY_TIMEOUT_EN.

## Test plan
- Normal operation entry (WIDTH=8):
  - Reset, then switches=0x12 + enter, 0x34 + enter, opSwitches=2 + enter.
  - Next cycle: operandA=0x12, operandB=0x34, opcode=2, entryReady=1, stage=3.
- Handshake:
  - Hold aluAck low for 10 cycles: outputs are unchanged and entryReady stays 1.
  - Pulse aluAck: the next cycle has entryReady=0 and stage=0.
- Clear mid-entry:
  - After operandA=0x12 is latched, clearValid + enterValid in the same cycle.
  - Result: stage=0, operandA=0, enter dropped.
- Ignored input in ISSUE: in ISSUE, pulse enterValid 3 times; state, entryReady and all operands stay unchanged.
- Asynchronous reset: drive resetN low between clock edges while in LOAD_OP; all outputs are 0 before the next edge.
- Timeout (macro on, TIMEOUT_TICKS=4):
  - Enter A, then idle: on the 4th idle cycle timeoutFlag=1 for one cycle, followed by stage=0 and operandA=0.
  - Repeat with enterValid on that 4th cycle: B is latched and no timeout occurs.
